// File: rtl/qspi_stream_ctrl.sv
// Streams flash contents into a downstream FIFO as fixed-size read commands,
// flagging one packet per PKT_BYTES bytes and reporting short chunks or overflow.
module qspi_stream_ctrl #(
    parameter int         ADDR_W      = 24,
    parameter int         CHUNK_BYTES = 256,
    parameter int         PKT_BYTES   = 1024,
    parameter int         FIFO_DEPTH  = 2048,
    parameter int         LVL_W       = 12,
    parameter logic [4:0] READ_TYPE   = 5'd9,
    parameter logic [7:0] READ_CMD    = 8'h6B
) (
    input  logic              clk_25M,
    input  logic              I_rst_n,
    input  logic              I_start,
    input  logic              I_abort,
    input  logic              I_mode,
    input  logic [ADDR_W-1:0] I_base_addr,
    input  logic [ADDR_W:0]   I_length,
    input  logic              I_done_sig,
    input  logic              I_byte_valid,
    input  logic [LVL_W-1:0]  I_wr_level,
    output logic [4:0]        O_cmd_type,
    output logic [7:0]        O_cmd_code,
    output logic [ADDR_W-1:0] O_flash_addr,
    output logic              O_tx_start,
    output logic              O_busy,
    output logic              O_done,
    output logic              O_err
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(CHUNK_BYTES + 1);
    localparam int PKT_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

    localparam logic [LEN_W-1:0]  PKT_L     = LEN_W'(PKT_BYTES);
    localparam logic [LEN_W-1:0]  CHUNK_L   = LEN_W'(CHUNK_BYTES);
    localparam logic [ADDR_W-1:0] CHUNK_A   = ADDR_W'(CHUNK_BYTES);
    localparam logic [CNT_W:0]    CHUNK_C   = (CNT_W+1)'(CHUNK_BYTES);
    localparam logic [LVL_W:0]    SPACE_LIM = (LVL_W+1)'(FIFO_DEPTH - CHUNK_BYTES);
    localparam logic [LVL_W:0]    FULL_LVL  = (LVL_W+1)'(FIFO_DEPTH);
    localparam logic [PKT_W-1:0]  PKT_LAST  = PKT_W'(PKT_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        READ,
        NEXT
    } state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [ADDR_W-1:0]  base_reg, base_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [LEN_W-1:0]   remaining_reg, remaining_next;
    logic               mode_reg, mode_next;
    logic [CNT_W-1:0]   chunk_cnt_reg, chunk_cnt_next;
    logic [PKT_W-1:0]   pkt_cnt_reg, pkt_cnt_next;
    logic               abort_pend_reg, abort_pend_next;
    logic               err_reg, err_next;
    logic               done_reg, done_next;
    logic               tx_start_reg, tx_start_next;

    logic [LEN_W-1:0]   eff_len;
    logic [LEN_W-1:0]   rem_after;
    logic [CNT_W:0]     chunk_total;
    logic               space_ok;
    logic               overflow;
    logic               err_set;
    logic               err_clr;

    assign eff_len     = I_length - (I_length % PKT_L);
    assign rem_after   = remaining_reg - CHUNK_L;
    // The strobe arriving with I_done_sig still belongs to the chunk being checked.
    assign chunk_total = {1'b0, chunk_cnt_reg} + (CNT_W+1)'(I_byte_valid);
    assign space_ok    = ({1'b0, I_wr_level} <= SPACE_LIM);
    assign overflow    = I_byte_valid && ({1'b0, I_wr_level} >= FULL_LVL);

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        base_next       = base_reg;
        len_next        = len_reg;
        remaining_next  = remaining_reg;
        mode_next       = mode_reg;
        chunk_cnt_next  = chunk_cnt_reg;
        pkt_cnt_next    = pkt_cnt_reg;
        abort_pend_next = abort_pend_reg;
        done_next       = 1'b0;
        tx_start_next   = 1'b0;
        err_set         = overflow;
        err_clr         = 1'b0;

        if (I_byte_valid) begin
            if (pkt_cnt_reg == PKT_LAST) begin
                pkt_cnt_next  = '0;
                tx_start_next = 1'b1;
            end else begin
                pkt_cnt_next = pkt_cnt_reg + PKT_W'(1);
            end
        end

        case (state_reg)
            IDLE: begin
                if (I_start && !I_abort) begin
                    if (eff_len != '0) begin
                        base_next       = I_base_addr;
                        len_next        = eff_len;
                        mode_next       = I_mode;
                        addr_next       = I_base_addr;
                        remaining_next  = eff_len;
                        pkt_cnt_next    = '0;
                        tx_start_next   = 1'b0;
                        chunk_cnt_next  = '0;
                        abort_pend_next = 1'b0;
                        err_clr         = 1'b1;
                        state_next      = WAIT_SPACE;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            WAIT_SPACE: begin
                if (I_abort) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (space_ok) begin
                    chunk_cnt_next = '0;
                    state_next     = READ;
                end
            end
            READ: begin
                if (I_byte_valid && (chunk_cnt_reg != '1)) begin
                    chunk_cnt_next = chunk_cnt_reg + CNT_W'(1);
                end
                if (I_abort) begin
                    abort_pend_next = 1'b1;
                end
                // The flash command is never cut short; an abort only takes effect here.
                if (I_done_sig) begin
                    if (chunk_total != CHUNK_C) begin
                        err_set = 1'b1;
                    end
                    if (abort_pend_reg || I_abort) begin
                        abort_pend_next = 1'b0;
                        done_next       = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        state_next = NEXT;
                    end
                end
            end
            NEXT: begin
                if (I_abort) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    addr_next      = addr_reg + CHUNK_A;
                    remaining_next = rem_after;
                    state_next     = WAIT_SPACE;
                    if (rem_after == '0) begin
                        if (mode_reg) begin
                            addr_next      = base_reg;
                            remaining_next = len_reg;
                        end else begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        err_next = err_clr ? 1'b0 : err_reg;
        if (err_set) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk_25M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            base_reg       <= '0;
            len_reg        <= '0;
            remaining_reg  <= '0;
            mode_reg       <= 1'b0;
            chunk_cnt_reg  <= '0;
            pkt_cnt_reg    <= '0;
            abort_pend_reg <= 1'b0;
            err_reg        <= 1'b0;
            done_reg       <= 1'b0;
            tx_start_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            base_reg       <= base_next;
            len_reg        <= len_next;
            remaining_reg  <= remaining_next;
            mode_reg       <= mode_next;
            chunk_cnt_reg  <= chunk_cnt_next;
            pkt_cnt_reg    <= pkt_cnt_next;
            abort_pend_reg <= abort_pend_next;
            err_reg        <= err_next;
            done_reg       <= done_next;
            tx_start_reg   <= tx_start_next;
        end
    end

    assign O_busy       = (state_reg != IDLE);
    assign O_cmd_type   = (state_reg == READ) ? READ_TYPE : 5'd0;
    assign O_cmd_code   = (state_reg == READ) ? READ_CMD : 8'd0;
    assign O_flash_addr = addr_reg;
    assign O_tx_start   = tx_start_reg;
    assign O_done       = done_reg;
    assign O_err        = err_reg;

endmodule
